systolic_os_engine: RTL and testbench
=====================================

// Module: systolic_os_engine
// PURPOSE
//   Output-stationary ARRAY_SIZE x ARRAY_SIZE signed matrix-multiply engine: C = A(NxK) * B(KxN), K runtime-set.
//   Next generation of our systolic array: adds operand skewing, valid/ready streaming, drain control,
//   wide accumulators and row-serial result readout. Sits between operand fetch and result writeback.
// PARAMETERS
//   ARRAY_SIZE  4                                  N: PE grid is N x N, C is N x N
//   DATA_WIDTH  8                                  signed operand width
//   MAX_K       16                                 max inner dimension per job
//   ACC_WIDTH   2*DATA_WIDTH+$clog2(MAX_K)         signed accumulator/result width
// PORTS
//   clk          in   1                  clock, rising edge
//   reset_n      in   1                  asynchronous active-low reset
//   start        in   1                  pulse in IDLE: begin job
//   k_len        in   $clog2(MAX_K)+1    inner dimension, sampled on accepted start; legal 1..MAX_K
//   in_valid     in   1                  operand beat valid
//   in_ready     out  1                  engine accepts operand beat
//   a_col        in   N*DATA_WIDTH       column k of A; slice r = A[r][k]
//   b_row        in   N*DATA_WIDTH       row k of B; slice c = B[k][c]
//   out_valid    out  1                  out_row valid
//   out_ready    in   1                  downstream accepts out_row
//   out_row      out  N*ACC_WIDTH        row out_idx of C; slice c = C[out_idx][c]
//   out_idx      out  $clog2(N)          row index of out_row
//   busy         out  1                  high in every state except IDLE
//   done         out  1                  one-cycle pulse after last row handshake
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; in_ready, out_valid, busy, done, out_idx = 0; all PE
//     accumulators, operand pipes, skew registers and counters = 0. Mid-job reset aborts the job silently.
//   FSM IDLE -> STREAM -> DRAIN -> OUTPUT -> IDLE.
//   IDLE: in_ready=0. start=1 with k_len in 1..MAX_K: clear all accumulators, latch k_len, -> STREAM.
//     start with k_len=0 or k_len>MAX_K ignored (stay IDLE). start outside IDLE ignored.
//   STREAM: in_ready=1. Beat accepted iff in_valid&&in_ready. Accepted beat pushed into skew network;
//     non-accepted cycle injects zeros (bubbles legal, result unaffected). Row r of A delayed r cycles,
//     column c of B delayed c cycles. Beat count reaches k_len -> DRAIN (in_ready=0 same edge onward).
//   PE(r,c): registers a (passes right), b (passes down); acc += sext(a*b) every cycle; zero operand adds 0.
//   DRAIN: zeros injected; lasts exactly 2*N-1 cycles counted from cycle after final beat, -> OUTPUT.
//   OUTPUT: out_valid=1, out_idx starts 0, out_row = accumulators of row out_idx (combinational mux).
//     out_valid&&out_ready advances out_idx; out_row/out_idx held stable while out_ready=0.
//     Handshake on out_idx=N-1: next cycle done=1, out_valid=0, state IDLE. Accumulators keep values until next start.
//   Arithmetic: signed DATA_WIDTH x DATA_WIDTH product sign-extended to ACC_WIDTH; sum wraps mod 2^ACC_WIDTH
//     (cannot overflow for legal k_len at default ACC_WIDTH).
//   Latency (no bubbles, out_ready=1): start -> first beat accepted next cycle; final beat -> out_valid after
//     2*N-1 DRAIN cycles + 1; N result cycles; done one cycle after last row.
//   start in same cycle as done: ignored (done cycle is IDLE-entry; start accepted from following cycle).
// STRUCTURE
//   Shared package systolic_pkg: FSM state encoding localparams (IDLE/STREAM/DRAIN/OUTPUT), default widths,
//     ACC_WIDTH derivation function, helper clog2.
//   Sub-module os_pe: one processing element (a/b pass registers, clear, signed MAC accumulator),
//     instantiated N*N via generate. Skew delay lines, FSM, counters, output mux live in top.
// TESTING (N=4, DATA_WIDTH=8, MAX_K=16, ACC_WIDTH=20)
//   A=I4, B[k][c]=4k+c, k_len=4, no bubbles -> rows read back equal B rows: row2 = {8,9,10,11}; done one pulse.
//   All operands +1, k_len=16 -> every C entry 16; all -128 with k_len=16 -> every entry 262144.
//   Random signed A,B, k_len=7, in_valid random 50% -> C matches golden model bit-exact; in_ready=0 outside STREAM.
//   out_ready low 5 cycles at out_idx=1 -> out_row/out_idx stable, no row skipped or duplicated.
//   reset_n low mid-STREAM for one cycle -> all outputs 0, state IDLE; fresh job afterwards correct.
//   start with k_len=0 -> busy stays 0; start during OUTPUT -> ignored, readout unaffected.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic engine.
//   state_e    : controller state encoding (IDLE/STREAM/DRAIN/OUTPUT)
//   DEF_*      : default geometry and operand widths
//   clog2      : ceiling log2 for parameter arithmetic
//   acc_width  : accumulator width that holds MAX_K full-scale products
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_e;

    localparam int DEF_ARRAY_SIZE = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_K      = 16;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

    function automatic int acc_width(input int data_width, input int max_k);
        return 2 * data_width + clog2(max_k);
    endfunction

endpackage

// File: rtl/os_pe.sv
// One output-stationary processing element.
//   clk, reset_n : clock, async active-low reset
//   clr_i        : synchronous accumulator clear (job start)
//   a_i / a_o    : A operand in, registered copy out to the right neighbour
//   b_i / b_o    : B operand in, registered copy out to the lower neighbour
//   acc_o        : signed running sum of a_i*b_i
module os_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = acc_width(DEF_DATA_WIDTH, DEF_MAX_K)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clr_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] a_o,
    output logic signed [DATA_WIDTH-1:0] b_o,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    logic signed [DATA_WIDTH-1:0]   a_q, b_q;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;

    // Operands are sign-extended before multiplying so the full signed product is kept.
    assign prod  = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
    assign acc_d = clr_i ? '0 : acc_q + ACC_WIDTH'(prod);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_os_engine.sv
// Output-stationary N x N signed matrix-multiply engine, C = A(NxK) * B(KxN).
//   clk, reset_n          : clock, async active-low reset
//   start, k_len          : job start (IDLE only) and inner dimension 1..MAX_K
//   in_valid/in_ready     : operand beat handshake; a_col = column k of A, b_row = row k of B
//   out_valid/out_ready   : result row handshake; out_row = C[out_idx][*]
//   busy, done            : not-IDLE flag, one-cycle completion pulse
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a legal start; accumulators hold the last result
// ST_STREAM | accepting k_len operand beats into the skew network
// ST_DRAIN  | 2N-1 zero cycles so the last beat reaches PE(N-1,N-1)
// ST_OUTPUT | presenting one C row per out_valid&&out_ready handshake
module systolic_os_engine
    import systolic_pkg::*;
#(
    parameter int  ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  MAX_K      = DEF_MAX_K,
    parameter int  ACC_WIDTH  = acc_width(DATA_WIDTH, MAX_K),
    localparam int KW         = clog2(MAX_K) + 1,
    localparam int IW         = (ARRAY_SIZE > 1) ? clog2(ARRAY_SIZE) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [KW-1:0]                    k_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_col,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] b_row,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_row,
    output logic [IW-1:0]                    out_idx,
    output logic                             busy,
    output logic                             done
);

    localparam int N   = ARRAY_SIZE;
    localparam int DW  = DATA_WIDTH;
    localparam int AW  = ACC_WIDTH;
    localparam int DCW = clog2(2*N);
    localparam logic [DCW-1:0] DRAIN_LEN = DCW'(2*N-1);
    localparam logic [KW-1:0]  K_MAX     = KW'(MAX_K);
    localparam logic [IW-1:0]  LAST_ROW  = IW'(N-1);

    state_e          state_q, state_d;
    logic [KW-1:0]   beats_left_q, beats_left_d;
    logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
    logic [IW-1:0]   out_idx_q, out_idx_d;
    logic            done_q, done_d;
    logic            accept, clr_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            beats_left_q <= '0;
            drain_cnt_q  <= '0;
            out_idx_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            drain_cnt_q  <= drain_cnt_d;
            out_idx_q    <= out_idx_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        drain_cnt_d  = drain_cnt_q;
        out_idx_d    = out_idx_q;
        done_d       = 1'b0;
        accept       = 1'b0;
        clr_acc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The done cycle is IDLE but a start seen there is dropped.
                if (start && !done_q && (k_len != '0) && (k_len <= K_MAX)) begin
                    clr_acc      = 1'b1;
                    beats_left_d = k_len;
                    state_d      = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (in_valid) begin
                    accept       = 1'b1;
                    beats_left_d = beats_left_q - KW'(1);
                    if (beats_left_q == KW'(1)) begin
                        drain_cnt_d = DRAIN_LEN;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q - DCW'(1);
                if (drain_cnt_q == DCW'(1)) state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    if (out_idx_q == LAST_ROW) begin
                        out_idx_d = '0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        out_idx_d = out_idx_q + IW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_STREAM);
    assign out_valid = (state_q == ST_OUTPUT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign out_idx   = out_idx_q;

    // a_h[r][c] / b_v[r][c] are the operands presented to PE(r,c).
    logic [DW-1:0] a_h [N][N];
    logic [DW-1:0] b_v [N][N];
    logic [AW-1:0] acc [N][N];
    logic [DW-1:0] a_edge_unused [N];
    logic [DW-1:0] b_edge_unused [N];

    // Row i of A and column i of B are delayed i cycles so that A[r][k] and
    // B[k][c] meet in PE(r,c). Non-accepted cycles inject zeros.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] a_in, b_in;
        assign a_in = accept ? a_col[i*DW +: DW] : '0;
        assign b_in = accept ? b_row[i*DW +: DW] : '0;
        if (i == 0) begin : g_nodly
            assign a_h[0][0] = a_in;
            assign b_v[0][0] = b_in;
        end else begin : g_dly
            logic [DW-1:0] a_dly_q [i];
            logic [DW-1:0] b_dly_q [i];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int s = 0; s < i; s++) begin
                        a_dly_q[s] <= '0;
                        b_dly_q[s] <= '0;
                    end
                end else begin
                    a_dly_q[0] <= a_in;
                    b_dly_q[0] <= b_in;
                    for (int s = 1; s < i; s++) begin
                        a_dly_q[s] <= a_dly_q[s-1];
                        b_dly_q[s] <= b_dly_q[s-1];
                    end
                end
            end
            assign a_h[i][0] = a_dly_q[i-1];
            assign b_v[0][i] = b_dly_q[i-1];
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [DW-1:0] a_pass, b_pass;
            os_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) u_pe (
                .clk     (clk),
                .reset_n (reset_n),
                .clr_i   (clr_acc),
                .a_i     (a_h[r][c]),
                .b_i     (b_v[r][c]),
                .a_o     (a_pass),
                .b_o     (b_pass),
                .acc_o   (acc[r][c])
            );
            if (c < N-1) begin : g_a_fwd
                assign a_h[r][c+1] = a_pass;
            end else begin : g_a_edge
                assign a_edge_unused[r] = a_pass;
            end
            if (r < N-1) begin : g_b_fwd
                assign b_v[r+1][c] = b_pass;
            end else begin : g_b_edge
                assign b_edge_unused[c] = b_pass;
            end
        end
    end

    always_comb begin
        out_row = '0;
        for (int c = 0; c < N; c++) out_row[c*AW +: AW] = acc[out_idx_q][c];
    end

endmodule

// File: tb/tb_systolic_os_engine.sv
// Self-checking bench for systolic_os_engine (N=4, 8-bit operands, MAX_K=16).
// Jobs come from a table; each job's expected C rows are computed by a plain
// matrix-multiply model and queued when the operands are generated, then
// popped and compared as the engine hands rows out.
module tb_systolic_os_engine;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXK = 16;
    localparam int AW   = 20;
    localparam int KW   = 5;
    localparam int IW   = 2;
    localparam int RW   = N*AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N*DW-1:0] a_col = '0;
    logic [N*DW-1:0] b_row = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_row;
    logic [IW-1:0] out_idx;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    systolic_os_engine #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (DW),
        .MAX_K      (MAXK),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_col     (a_col),
        .b_row     (b_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int            idx;
        logic [RW-1:0] row;
    } exp_t;

    typedef struct {
        int            pat;          // 0 identity/ramp, 1 all +1, 2 all -128, 3 random
        int            kl;
        int            vpct;         // in_valid probability
        int            opct;         // out_ready probability
        int            exp_const;    // every C entry, or -1
        bit            chk_row2;
        logic [RW-1:0] exp_row2;
        bit            stall1;       // hold out_ready low 5 cycles at out_idx=1
        bit            start_in_out; // pulse start during OUTPUT
        bit            start_at_done;
    } job_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ga [N][MAXK];
    int   gb [MAXK][N];
    exp_t sb_q [$];

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic gen_and_push(input int pat, input int kl);
        logic [RW-1:0] row;
        int s;
        for (int k = 0; k < MAXK; k++) begin
            for (int i = 0; i < N; i++) begin
                case (pat)
                    0:       begin ga[i][k] = (i == k) ? 1 : 0; gb[k][i] = 4*k + i; end
                    1:       begin ga[i][k] = 1;    gb[k][i] = 1;    end
                    2:       begin ga[i][k] = -128; gb[k][i] = -128; end
                    default: begin
                        ga[i][k] = int'($urandom_range(255)) - 128;
                        gb[k][i] = int'($urandom_range(255)) - 128;
                    end
                endcase
            end
        end
        for (int r = 0; r < N; r++) begin
            row = '0;
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int k = 0; k < kl; k++) s += ga[r][k] * gb[k][c];
                row[c*AW +: AW] = AW'(s);
            end
            sb_q.push_back('{idx: r, row: row});
        end
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < N; i++) begin
            a_col[i*DW +: DW] = DW'(ga[i][k]);
            b_row[i*DW +: DW] = DW'(gb[k][i]);
        end
    endtask

    task automatic run_job(input job_t j);
        int   beat, cyc, lat, got;
        bit   v, rdy, orr, stalled, first;
        exp_t e;
        sb_q.delete();
        gen_and_push(j.pat, j.kl);

        @(negedge clk);
        start = 1'b1;
        k_len = KW'(j.kl);
        @(negedge clk);
        start = 1'b0;
        check_int("busy_after_start", int'(busy), 1);
        check_int("in_ready_stream", int'(in_ready), 1);

        beat = 0;
        cyc  = 0;
        while (beat < j.kl) begin
            if (cyc > 400) begin timeout("stream"); break; end
            v = ($urandom_range(99) < j.vpct);
            in_valid = v;
            if (v) drive_beat(beat);
            else begin a_col = $urandom; b_row = $urandom; end
            rdy = in_ready;
            @(negedge clk);
            cyc++;
            if (v && rdy) beat++;
        end

        // Keep in_valid high with junk after the last beat: it must be ignored.
        in_valid = 1'b1;
        a_col = $urandom;
        b_row = $urandom;
        check_int("in_ready_after_last_beat", int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_int("drain_latency", lat, 2*N-1);
        check_int("in_ready_in_output", int'(in_ready), 0);

        got = 0;
        cyc = 0;
        stalled = 1'b0;
        first = 1'b1;
        while (got < N) begin
            if (cyc > 200) begin timeout("readout"); break; end
            start = (j.start_in_out && first);
            k_len = KW'(3);
            first = 1'b0;
            if (j.stall1 && !stalled && out_valid && out_idx == IW'(1) && sb_q.size() > 0) begin
                for (int s = 0; s < 5; s++) begin
                    out_ready = 1'b0;
                    @(negedge clk);
                    start = 1'b0;
                    check_int("stall_out_valid", int'(out_valid), 1);
                    check_int("stall_out_idx", int'(out_idx), 1);
                    check_row("stall_out_row", out_row, sb_q[0].row);
                end
                stalled = 1'b1;
            end
            orr = ($urandom_range(99) < j.opct);
            out_ready = orr;
            if (out_valid && orr && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_int("out_idx", int'(out_idx), e.idx);
                check_row("out_row", out_row, e.row);
                if (j.exp_const >= 0)
                    for (int c = 0; c < N; c++)
                        check_int("const_entry", int'(out_row[c*AW +: AW]), j.exp_const);
                if (j.chk_row2 && e.idx == 2)
                    check_row("identity_row2", out_row, j.exp_row2);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        check_int("done_pulse", int'(done), 1);
        check_int("out_valid_after_last", int'(out_valid), 0);
        check_int("busy_in_done_cycle", int'(busy), 0);
        if (j.start_at_done) begin
            start = 1'b1;
            k_len = KW'(3);
        end
        @(negedge clk);
        start = 1'b0;
        check_int("done_cleared", int'(done), 0);
        check_int("busy_after_done", int'(busy), 0);
        check_int("scoreboard_empty", sb_q.size(), 0);
    endtask

    initial begin
        job_t jobs [8];

        jobs[0] = '{0, 4,  100, 100, -1,     1'b1, {20'd11, 20'd10, 20'd9, 20'd8}, 1'b0, 1'b0, 1'b0};
        jobs[1] = '{1, 16, 100, 100, 16,     1'b0, '0, 1'b0, 1'b0, 1'b0};
        jobs[2] = '{2, 16, 100, 100, 262144, 1'b0, '0, 1'b0, 1'b0, 1'b0};
        jobs[3] = '{3, 7,  50,  100, -1,     1'b0, '0, 1'b0, 1'b0, 1'b0};
        jobs[4] = '{3, 7,  50,  100, -1,     1'b0, '0, 1'b1, 1'b0, 1'b0};
        jobs[5] = '{3, 5,  100, 60,  -1,     1'b0, '0, 1'b0, 1'b1, 1'b1};
        jobs[6] = '{3, 1,  70,  70,  -1,     1'b0, '0, 1'b0, 1'b0, 1'b0};
        jobs[7] = '{3, 16, 60,  80,  -1,     1'b0, '0, 1'b0, 1'b0, 1'b0};

        // Reset state.
        @(negedge clk);
        check_int("rst_in_ready", int'(in_ready), 0);
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_out_idx", int'(out_idx), 0);
        check_row("rst_out_row", out_row, '0);
        reset_n = 1'b1;

        // Illegal k_len values are ignored.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start = 1'b1;
            k_len = (t == 0) ? KW'(0) : KW'(17);
            @(negedge clk);
            start = 1'b0;
            check_int("bad_klen_busy", int'(busy), 0);
            check_int("bad_klen_in_ready", int'(in_ready), 0);
            @(negedge clk);
            check_int("bad_klen_busy_later", int'(busy), 0);
        end

        for (int j = 0; j < 8; j++) run_job(jobs[j]);

        // Abort mid-STREAM with a one-cycle reset, then run a clean job.
        gen_and_push(3, 8);
        sb_q.delete();
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(8);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            drive_beat(k);
            @(negedge clk);
        end
        check_int("pre_reset_busy", int'(busy), 1);
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_int("mid_rst_busy", int'(busy), 0);
        check_int("mid_rst_in_ready", int'(in_ready), 0);
        check_int("mid_rst_out_valid", int'(out_valid), 0);
        check_int("mid_rst_done", int'(done), 0);
        check_int("mid_rst_out_idx", int'(out_idx), 0);
        check_row("mid_rst_out_row", out_row, '0);
        @(negedge clk);
        reset_n = 1'b1;
        run_job('{3, 6, 80, 90, -1, 1'b0, '0, 1'b0, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
